// File: rtl/noc_pkg.sv
// Shared types, header layout and header builder for the NoC local injector.
package noc_pkg;

  localparam int unsigned NOC_XY_SZ   = 3;
  localparam int unsigned HDR_W       = 32;
  localparam int unsigned HDR_DST_LSB = 0;
  localparam int unsigned HDR_SRC_LSB = 2 * NOC_XY_SZ;
  localparam int unsigned HDR_LEN_LSB = 16;
  localparam int unsigned HDR_LEN_W   = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HDR   = 2'd1,
    DRAIN = 2'd2
  } inj_state_e;

  // id_w is the width of one {Y,X} id; the source id sits directly above the destination
  function automatic logic [HDR_W-1:0] hdr_build(
    input logic [HDR_LEN_W-1:0] len,
    input logic [15:0]          src,
    input logic [15:0]          dst,
    input int unsigned          id_w
  );
    hdr_build = (HDR_W'(dst) << HDR_DST_LSB)
              | (HDR_W'(src) << (HDR_DST_LSB + id_w))
              | (HDR_W'(len) << HDR_LEN_LSB);
  endfunction

endpackage

// File: rtl/noc_inj_buf.sv
// Single-packet payload store: one write port, one registered read port.
// A read that hits the address being written returns the new data.
module noc_inj_buf
  import noc_pkg::*;
#(
  parameter int unsigned DW = 36,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/noc_local_injector.sv
// Store-and-forward packetizer: buffers one payload packet, then emits header + payload.
// Optional NOC_LOCAL_INJ_STATS_EN adds pkt_count / beat_count outputs.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int unsigned BW                = 32,
  parameter int unsigned BWB               = BW / 8,
  parameter int unsigned XY_SZ             = NOC_XY_SZ,
  parameter int unsigned NOC_BUFFER_ADDR_W = 8
) (
  input  logic                 clk_line,
  input  logic                 clk_line_rst_low,
  input  logic [2*XY_SZ-1:0]   HsrcId,
  input  logic [2*XY_SZ-1:0]   dst_id,
  input  logic                 stream_in_TVALID,
  output logic                 stream_in_TREADY,
  input  logic [BW-1:0]        stream_in_TDATA,
  input  logic [BWB-1:0]       stream_in_TKEEP,
  input  logic                 stream_in_TLAST,
  output logic                 stream_out_TVALID,
  input  logic                 stream_out_TREADY,
  output logic [BW-1:0]        stream_out_TDATA,
  output logic [BWB-1:0]       stream_out_TKEEP,
  output logic                 stream_out_TLAST,
  output logic                 busy,
  output logic                 err_oversize
`ifdef NOC_LOCAL_INJ_STATS_EN
  ,
  output logic [31:0]          pkt_count,
  output logic [31:0]          beat_count
`endif
);

  localparam int unsigned AW  = NOC_BUFFER_ADDR_W;
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned IDW = 2 * XY_SZ;
  localparam int unsigned DW  = BW + BWB;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** AW);

  inj_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDW-1:0]  dst_q, dst_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [BW-1:0]   out_data_q, out_data_d;
  logic [BWB-1:0]  out_keep_q, out_keep_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            in_fire, out_fire;
  logic            buf_we, buf_re;
  logic [AW-1:0]   buf_raddr;
  logic [DW-1:0]   buf_rdata;

  assign in_fire  = stream_in_TVALID && in_ready_q;
  assign out_fire = out_valid_q && stream_out_TREADY;

  noc_inj_buf #(.DW(DW), .AW(AW)) u_buf (
    .clk   (clk_line),
    .rst_n (clk_line_rst_low),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata ({stream_in_TDATA, stream_in_TKEEP}),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // rd_ptr tracks the payload index on the output; the buffer read port runs one entry ahead
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dst_d       = dst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    buf_we      = 1'b0;
    buf_re      = 1'b0;
    buf_raddr   = rd_ptr_q;

    case (state_q)
      FILL: begin
        buf_re    = 1'b1;
        buf_raddr = '0;
        buf_we    = in_fire;
        if (in_fire) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
          if (count_q == '0) dst_d = dst_id;
          if (stream_in_TLAST || (count_d == DEPTH)) begin
            state_d     = HDR;
            out_valid_d = 1'b1;
            out_keep_d  = '1;
            out_last_d  = 1'b0;
            out_data_d  = BW'(hdr_build(HDR_LEN_W'(count_d), 16'(HsrcId), 16'(dst_d), IDW));
            if (!stream_in_TLAST) err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (out_fire) begin
          state_d    = DRAIN;
          out_data_d = buf_rdata[DW-1:BWB];
          out_keep_d = buf_rdata[BWB-1:0];
          out_last_d = (count_q == CW'(1));
          rd_ptr_d   = '0;
          buf_re     = 1'b1;
          buf_raddr  = rd_ptr_q + AW'(1);
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last_q) begin
            state_d     = FILL;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
          end else begin
            out_data_d = buf_rdata[DW-1:BWB];
            out_keep_d = buf_rdata[BWB-1:0];
            out_last_d = ((CW'(rd_ptr_q) + CW'(2)) == count_q);
            rd_ptr_d   = rd_ptr_q + AW'(1);
            buf_re     = 1'b1;
            buf_raddr  = rd_ptr_q + AW'(2);
          end
        end
      end
      default: begin
      end
    endcase

    in_ready_d = (state_d == FILL) && (count_d < DEPTH);
    busy_d     = (state_d != FILL);
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      state_q     <= FILL;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dst_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dst_q       <= dst_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign stream_in_TREADY  = in_ready_q;
  assign stream_out_TVALID = out_valid_q;
  assign stream_out_TDATA  = out_data_q;
  assign stream_out_TKEEP  = out_keep_q;
  assign stream_out_TLAST  = out_last_q;
  assign busy              = busy_q;
  assign err_oversize      = err_q;

`ifdef NOC_LOCAL_INJ_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] beat_count_q, beat_count_d;

  always_comb begin
    pkt_count_d  = pkt_count_q + 32'((state_q == DRAIN) && out_fire && out_last_q);
    beat_count_d = beat_count_q + 32'(out_fire);
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Self-checking bench for noc_local_injector (4-entry buffer) against a queue-based packet model.
module tb_noc_local_injector;

  localparam int unsigned BW    = 32;
  localparam int unsigned BWB   = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } flit_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [5:0]  dst;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [5:0]      HsrcId, dst_id;
  logic            stream_in_TVALID, stream_in_TREADY;
  logic [BW-1:0]   stream_in_TDATA;
  logic [BWB-1:0]  stream_in_TKEEP;
  logic            stream_in_TLAST;
  logic            stream_out_TVALID, stream_out_TREADY;
  logic [BW-1:0]   stream_out_TDATA;
  logic [BWB-1:0]  stream_out_TKEEP;
  logic            stream_out_TLAST;
  logic            busy, err_oversize;
`ifdef NOC_LOCAL_INJ_STATS_EN
  logic [31:0]     pkt_count, beat_count;
`endif

  int errors = 0;
  int checks = 0;

  beat_t      inq[$];
  flit_t      expq[$];
  flit_t      cur[$];
  logic [5:0] cur_dst;
  bit         err_exp;
  int         pkt_exp, beat_exp;
  int         mode;
  logic       rdy;

  always #5 clk = ~clk;

  noc_local_injector #(.NOC_BUFFER_ADDR_W(AW)) dut (
    .clk_line          (clk),
    .clk_line_rst_low  (rst_n),
    .HsrcId            (HsrcId),
    .dst_id            (dst_id),
    .stream_in_TVALID  (stream_in_TVALID),
    .stream_in_TREADY  (stream_in_TREADY),
    .stream_in_TDATA   (stream_in_TDATA),
    .stream_in_TKEEP   (stream_in_TKEEP),
    .stream_in_TLAST   (stream_in_TLAST),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TREADY (stream_out_TREADY),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .busy              (busy),
    .err_oversize      (err_oversize)
`ifdef NOC_LOCAL_INJ_STATS_EN
    ,
    .pkt_count         (pkt_count),
    .beat_count        (beat_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet model: split accepted beats at TLAST or when the buffer is full
  task automatic model_accept(input beat_t b);
    flit_t f;
    if (cur.size() == 0) cur_dst = b.dst;
    f.d = b.d; f.k = b.k; f.l = 1'b0;
    cur.push_back(f);
    if (b.l || cur.size() == DEPTH) begin
      if (!b.l) err_exp = 1'b1;
      f.d = (32'(cur.size()) << 16) | (32'(HsrcId) << 6) | 32'(cur_dst);
      f.k = 4'hF; f.l = 1'b0;
      expq.push_back(f);
      for (int i = 0; i < cur.size(); i++) begin
        f = cur[i];
        f.l = (i == cur.size() - 1);
        expq.push_back(f);
      end
      cur.delete();
    end
  endtask

  task automatic push_pkt(input int n, input logic [5:0] dst, input bit rnd, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d   = rnd ? $urandom : base + 32'(i);
      b.k   = rnd ? 4'($urandom) : 4'hF;
      b.l   = (i == n - 1);
      b.dst = (i == 0 || !rnd) ? dst : 6'($urandom);
      inq.push_back(b);
    end
  endtask

  // One clock: check outputs at the falling edge, then drive and book the coming handshakes
  task automatic cycle();
    @(negedge clk);
    chk("out_valid", 64'(stream_out_TVALID), 64'(expq.size() != 0));
    chk("busy", 64'(busy), 64'(expq.size() != 0));
    chk("in_ready", 64'(stream_in_TREADY), 64'(expq.size() == 0));
    chk("err_oversize", 64'(err_oversize), 64'(err_exp));
    if (stream_out_TVALID && expq.size() != 0) begin
      chk("out_data", 64'(stream_out_TDATA), 64'(expq[0].d));
      chk("out_keep", 64'(stream_out_TKEEP), 64'(expq[0].k));
      chk("out_last", 64'(stream_out_TLAST), 64'(expq[0].l));
    end
    case (mode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      default: rdy = ($urandom_range(3) != 0);
    endcase
    stream_out_TREADY = rdy;
    if (inq.size() != 0 && (mode != 2 || $urandom_range(3) != 0)) begin
      stream_in_TVALID = 1'b1;
      stream_in_TDATA  = inq[0].d;
      stream_in_TKEEP  = inq[0].k;
      stream_in_TLAST  = inq[0].l;
      dst_id           = inq[0].dst;
    end else begin
      stream_in_TVALID = 1'b0;
      stream_in_TLAST  = 1'b0;
      dst_id           = 6'($urandom);
    end
    if (stream_out_TVALID && rdy && expq.size() != 0) begin
      beat_exp++;
      if (expq[0].l) pkt_exp++;
      void'(expq.pop_front());
    end
    if (stream_in_TVALID && stream_in_TREADY) begin
      model_accept(inq[0]);
      void'(inq.pop_front());
    end
  endtask

  task automatic run(input int m);
    int n;
    mode = m;
    n = 0;
    while ((inq.size() != 0 || expq.size() != 0) && n < 3000) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(inq.size() + expq.size()), 64'd0);
    mode = 0;
    repeat (2) cycle();
  endtask

  task automatic stats_chk(input string tag);
`ifdef NOC_LOCAL_INJ_STATS_EN
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(pkt_exp));
    chk({tag, "_beat_count"}, 64'(beat_count), 64'(beat_exp));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  task automatic wait_hdr(input logic [31:0] hdr);
    int n;
    n = 0;
    while (!stream_out_TVALID && n < 20) begin
      cycle();
      n++;
    end
    chk("hdr_literal", 64'(stream_out_TDATA), 64'(hdr));
  endtask

  task automatic model_clear();
    inq.delete(); expq.delete(); cur.delete();
    err_exp = 1'b0; pkt_exp = 0; beat_exp = 0;
  endtask

  initial begin
    beat_t b;
    int n;
    rst_n = 1'b0;
    HsrcId = 6'o12;
    dst_id = '0;
    stream_in_TVALID = 1'b0;
    stream_in_TDATA  = '0;
    stream_in_TKEEP  = '0;
    stream_in_TLAST  = 1'b0;
    stream_out_TREADY = 1'b0;
    rdy = 1'b0;
    mode = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(stream_out_TVALID), 64'd0);
    chk("rst_in_ready", 64'(stream_in_TREADY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_oversize), 64'd0);
    chk("rst_out_data", 64'(stream_out_TDATA), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 3-beat packet, sink always ready
    push_pkt(3, 6'o34, 1'b0, 32'hA);
    wait_hdr(32'h0003_029C);
    run(0);

    // Same packet with the sink toggling ready every cycle
    push_pkt(3, 6'o34, 1'b0, 32'hA);
    run(1);
    stats_chk("two_pkts");
`ifdef NOC_LOCAL_INJ_STATS_EN
    chk("pkt_count_lit", 64'(pkt_count), 64'd2);
    chk("beat_count_lit", 64'(beat_count), 64'd8);
`endif

    // Single-beat packet
    push_pkt(1, 6'o34, 1'b0, 32'h55);
    wait_hdr(32'h0001_029C);
    run(0);

    // Six beats into a four-entry buffer: truncation, second packet takes beat-5 dst
    for (int i = 0; i < 6; i++) begin
      b.d = 32'h100 + 32'(i); b.k = 4'hF; b.l = (i == 5);
      b.dst = (i < 4) ? 6'o21 : 6'o45;
      inq.push_back(b);
    end
    wait_hdr(32'h0004_0291);
    run(0);
    chk("err_sticky", 64'(err_oversize), 64'd1);

    // Random packets, random gaps and backpressure
    for (int p = 0; p < 12; p++) push_pkt($urandom_range(1, 6), 6'($urandom), 1'b1, 32'h0);
    run(2);
    stats_chk("random");

    // Reset in the middle of the payload
    push_pkt(3, 6'o07, 1'b0, 32'h200);
    mode = 0;
    n = 0;
    while (expq.size() != 2 && n < 50) begin
      cycle();
      n++;
    end
    @(negedge clk);
    chk("pre_rst_valid", 64'(stream_out_TVALID), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(stream_out_TVALID), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err_oversize), 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_pkt(3, 6'o34, 1'b0, 32'h300);
    wait_hdr(32'h0003_029C);
    run(0);
    stats_chk("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
